// File: rtl/muldiv_arbiter_if.sv
// Request, unit-issue and writeback signals of the shared MUL/DIV arbiter.
// slave is the arbiter's view; master is the pipeline/unit view.
interface muldiv_arbiter_if #(
    parameter int N_HARTS    = 4,
    parameter int HART_ID_W  = 2,
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OP_W       = 3
);
    logic [N_HARTS-1:0]            req_valid;
    logic [N_HARTS*OP_W-1:0]       req_op;
    logic [N_HARTS*XLEN-1:0]       req_a;
    logic [N_HARTS*XLEN-1:0]       req_b;
    logic [N_HARTS*REG_ADDR_W-1:0] req_rd;
    logic [N_HARTS-1:0]            req_ready;
    logic [N_HARTS-1:0]            hart_pending;
    logic                          mdu_valid;
    logic [OP_W-1:0]               mdu_op;
    logic [XLEN-1:0]               mdu_a;
    logic [XLEN-1:0]               mdu_b;
    logic [HART_ID_W-1:0]          mdu_hart_id;
    logic [REG_ADDR_W-1:0]         mdu_rd;
    logic                          mdu_busy;
    logic                          mdu_done;
    logic [XLEN-1:0]               mdu_result;
    logic [HART_ID_W-1:0]          mdu_done_hart_id;
    logic [REG_ADDR_W-1:0]         mdu_done_rd;
    logic                          wb_valid;
    logic [HART_ID_W-1:0]          wb_hart_id;
    logic [REG_ADDR_W-1:0]         wb_rd;
    logic [XLEN-1:0]               wb_data;
    logic                          arb_err;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_rd,
        input  mdu_busy, mdu_done, mdu_result, mdu_done_hart_id, mdu_done_rd,
        output req_ready, hart_pending,
        output mdu_valid, mdu_op, mdu_a, mdu_b, mdu_hart_id, mdu_rd,
        output wb_valid, wb_hart_id, wb_rd, wb_data, arb_err
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_rd,
        output mdu_busy, mdu_done, mdu_result, mdu_done_hart_id, mdu_done_rd,
        input  req_ready, hart_pending,
        input  mdu_valid, mdu_op, mdu_a, mdu_b, mdu_hart_id, mdu_rd,
        input  wb_valid, wb_hart_id, wb_rd, wb_data, arb_err
    );
endinterface

// File: rtl/muldiv_arbiter.sv
// Round-robin arbiter sharing one multi-cycle MUL/DIV unit among harts.
// Define MULDIV_ARB_TIMEOUT_EN to add a WAIT watchdog of TIMEOUT cycles.
module muldiv_arbiter #(
    parameter int N_HARTS    = 4,
    parameter int HART_ID_W  = 2,
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OP_W       = 3,
    parameter int TIMEOUT    = 64
) (
    input logic             clk,
    input logic             rst_n,
    muldiv_arbiter_if.slave bus
);
    // state | meaning
    // IDLE  | arbitrating; req_ready may be asserted
    // ISSUE | mdu_valid pulse with the captured operands
    // WAIT  | operation in flight, waiting for mdu_done
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [HART_ID_W-1:0]    ptr;
    logic [HART_ID_W-1:0]    ptr_nxt;
    logic [HART_ID_W-1:0]    grant_id;
    logic [N_HARTS-1:0]      grant_vec;
    logic [N_HARTS-1:0]      eligible;
    logic [N_HARTS-1:0]      pending;
    logic                    grant_any;
    logic                    timeout_hit;
    logic                    op_end;
    logic [OP_W-1:0]         cap_op;
    logic [XLEN-1:0]         cap_a;
    logic [XLEN-1:0]         cap_b;
    logic [HART_ID_W-1:0]    cap_hart;
    logic [REG_ADDR_W-1:0]   cap_rd;
    logic                    wb_valid;
    logic [HART_ID_W-1:0]    wb_hart_id;
    logic [REG_ADDR_W-1:0]   wb_rd;
    logic [XLEN-1:0]         wb_data;
    logic                    arb_err;

    if ((2 ** HART_ID_W) < N_HARTS || TIMEOUT < 1) begin : g_bad_cfg
        $error("muldiv_arbiter: HART_ID_W too narrow or TIMEOUT < 1");
    end

    assign eligible = bus.req_valid & ~pending;

    // Search starts at ptr and wraps, so the first match is the round-robin winner.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vec = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        if (state == IDLE && !bus.mdu_busy) begin
            for (int i = 0; i < N_HARTS; i++) begin
                idx = int'(ptr) + i;
                if (idx >= N_HARTS) idx = idx - N_HARTS;
                if (!grant_any && eligible[HART_ID_W'(idx)]) begin
                    grant_any = 1'b1;
                    grant_id  = HART_ID_W'(idx);
                end
            end
            if (grant_any) grant_vec[grant_id] = 1'b1;
        end
    end

    assign ptr_nxt = (grant_id == HART_ID_W'(N_HARTS - 1)) ? '0 : grant_id + 1'b1;
    assign op_end  = (state == WAIT) && (bus.mdu_done || timeout_hit);

`ifdef MULDIV_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] tmr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr <= '0;
        end else if (state == ISSUE) begin
            tmr <= TMR_W'(TIMEOUT - 1);
        end else if (state == WAIT && tmr != '0) begin
            tmr <= tmr - 1'b1;
        end
    end

    assign timeout_hit = (state == WAIT) && (tmr == '0) && !bus.mdu_done;
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant_any) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (op_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = grant_vec;
        bus.mdu_valid = (state == ISSUE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            pending    <= '0;
            cap_op     <= '0;
            cap_a      <= '0;
            cap_b      <= '0;
            cap_hart   <= '0;
            cap_rd     <= '0;
            wb_valid   <= 1'b0;
            wb_hart_id <= '0;
            wb_rd      <= '0;
            wb_data    <= '0;
            arb_err    <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            if (grant_any) begin
                ptr      <= ptr_nxt;
                pending  <= grant_vec;
                cap_op   <= bus.req_op[grant_id*OP_W +: OP_W];
                cap_a    <= bus.req_a[grant_id*XLEN +: XLEN];
                cap_b    <= bus.req_b[grant_id*XLEN +: XLEN];
                cap_rd   <= bus.req_rd[grant_id*REG_ADDR_W +: REG_ADDR_W];
                cap_hart <= grant_id;
            end
            // Writeback tags come from the capture, never from the unit.
            if (op_end) begin
                wb_valid   <= 1'b1;
                wb_hart_id <= cap_hart;
                wb_rd      <= cap_rd;
                wb_data    <= bus.mdu_done ? bus.mdu_result : '0;
                pending    <= '0;
                if (timeout_hit || bus.mdu_done_hart_id != cap_hart || bus.mdu_done_rd != cap_rd)
                    arb_err <= 1'b1;
            end
            if (bus.mdu_done && state != WAIT) arb_err <= 1'b1;
        end
    end

    assign bus.hart_pending = pending;
    assign bus.mdu_op       = cap_op;
    assign bus.mdu_a        = cap_a;
    assign bus.mdu_b        = cap_b;
    assign bus.mdu_hart_id  = cap_hart;
    assign bus.mdu_rd       = cap_rd;
    assign bus.wb_valid     = wb_valid;
    assign bus.wb_hart_id   = wb_hart_id;
    assign bus.wb_rd        = wb_rd;
    assign bus.wb_data      = wb_data;
    assign bus.arb_err      = arb_err;
endmodule

// File: tb/tb_muldiv_arbiter.sv
// Self-checking bench for muldiv_arbiter: directed scenarios plus randomized
// traffic checked against a round-robin reference model.
module tb_muldiv_arbiter;
    localparam int N  = 4;
    localparam int HW = 2;
    localparam int XL = 32;
    localparam int RW = 5;
    localparam int OW = 3;
    localparam int TO = 64;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;
    int   model_ptr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    muldiv_arbiter_if #(.N_HARTS(N), .HART_ID_W(HW), .XLEN(XL), .REG_ADDR_W(RW), .OP_W(OW)) bus ();

    muldiv_arbiter #(.N_HARTS(N), .HART_ID_W(HW), .XLEN(XL), .REG_ADDR_W(RW), .OP_W(OW),
                     .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic idle_inputs();
        bus.req_valid        = '0;
        bus.req_op           = '0;
        bus.req_a            = '0;
        bus.req_b            = '0;
        bus.req_rd           = '0;
        bus.mdu_busy         = 1'b0;
        bus.mdu_done         = 1'b0;
        bus.mdu_result       = '0;
        bus.mdu_done_hart_id = '0;
        bus.mdu_done_rd      = '0;
    endtask

    task automatic set_req(input int h, input logic [OW-1:0] op, input logic [XL-1:0] a,
                           input logic [XL-1:0] b, input logic [RW-1:0] rd);
        bus.req_op[h*OW +: OW] = op;
        bus.req_a[h*XL +: XL]  = a;
        bus.req_b[h*XL +: XL]  = b;
        bus.req_rd[h*RW +: RW] = rd;
    endtask

    task automatic unit_done(input logic [XL-1:0] res, input int h, input logic [RW-1:0] rd);
        bus.mdu_done         = 1'b1;
        bus.mdu_result       = res;
        bus.mdu_done_hart_id = HW'(h);
        bus.mdu_done_rd      = rd;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
    endtask

    // Reference: first requesting hart at or after the pointer, wrapping; none while busy.
    function automatic int model_pick(input logic [N-1:0] req, input logic busy);
        if (busy) return -1;
        for (int k = 0; k < N; k++)
            if (req[(model_ptr + k) % N]) return (model_ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int h);
        logic [N-1:0] v;
        v = '0;
        if (h >= 0) v[h] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({bus.req_ready, bus.hart_pending, bus.mdu_valid, bus.wb_valid, bus.arb_err} !== '0)
            $display("FAIL reset_ctrl: ready=%b pend=%b mv=%b wv=%b err=%b expected all 0",
                     bus.req_ready, bus.hart_pending, bus.mdu_valid, bus.wb_valid, bus.arb_err);
        else pass_cnt++;
        total_cnt++;
        if ({bus.mdu_op, bus.mdu_a, bus.mdu_b, bus.mdu_hart_id, bus.mdu_rd,
             bus.wb_hart_id, bus.wb_rd, bus.wb_data} !== '0)
            $display("FAIL reset_data: mdu_a=%h mdu_b=%h wb_data=%h expected 0",
                     bus.mdu_a, bus.mdu_b, bus.wb_data);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
        @(negedge clk);
        #1;
        total_cnt++;
        if ({bus.req_ready, bus.mdu_valid, bus.wb_valid} !== '0)
            $display("FAIL reset_idle: ready=%b mv=%b wv=%b expected 0",
                     bus.req_ready, bus.mdu_valid, bus.wb_valid);
        else pass_cnt++;
    endtask

    task automatic test_single();
        apply_reset();
        @(negedge clk);
        bus.req_valid = 4'b0010;
        set_req(1, 3'd0, 32'd7, 32'd6, 5'd5);
        #1;
        total_cnt++;
        if (bus.req_ready !== 4'b0010)
            $display("FAIL single_grant: req_ready=%b expected 0010", bus.req_ready);
        else pass_cnt++;
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        total_cnt++;
        if ({bus.mdu_valid, bus.mdu_hart_id, bus.mdu_rd, bus.mdu_op, bus.mdu_a, bus.mdu_b}
            !== {1'b1, 2'd1, 5'd5, 3'd0, 32'd7, 32'd6})
            $display("FAIL single_issue: mv=%b hart=%0d rd=%0d op=%0d a=%0d b=%0d expected 1 1 5 0 7 6",
                     bus.mdu_valid, bus.mdu_hart_id, bus.mdu_rd, bus.mdu_op, bus.mdu_a, bus.mdu_b);
        else pass_cnt++;
        total_cnt++;
        if (bus.hart_pending !== 4'b0010)
            $display("FAIL single_pend_issue: pending=%b expected 0010", bus.hart_pending);
        else pass_cnt++;
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            #1;
            total_cnt++;
            if ({bus.mdu_valid, bus.hart_pending, bus.wb_valid} !== {1'b0, 4'b0010, 1'b0})
                $display("FAIL single_wait: mv=%b pend=%b wv=%b expected 0 0010 0",
                         bus.mdu_valid, bus.hart_pending, bus.wb_valid);
            else pass_cnt++;
        end
        @(negedge clk);
        unit_done(32'd42, 1, 5'd5);
        #1;
        total_cnt++;
        if (bus.hart_pending !== 4'b0010)
            $display("FAIL single_pend_done: pending=%b expected 0010", bus.hart_pending);
        else pass_cnt++;
        @(negedge clk);
        bus.mdu_done = 1'b0;
        #1;
        total_cnt++;
        if ({bus.wb_valid, bus.wb_hart_id, bus.wb_rd, bus.wb_data} !== {1'b1, 2'd1, 5'd5, 32'd42})
            $display("FAIL single_wb: wv=%b hart=%0d rd=%0d data=%0d expected 1 1 5 42",
                     bus.wb_valid, bus.wb_hart_id, bus.wb_rd, bus.wb_data);
        else pass_cnt++;
        total_cnt++;
        if (bus.arb_err !== 1'b0)
            $display("FAIL single_err: arb_err=%b expected 0", bus.arb_err);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if ({bus.wb_valid, bus.hart_pending} !== 5'b0)
            $display("FAIL single_after: wv=%b pend=%b expected 0 0000", bus.wb_valid, bus.hart_pending);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int exp_h;
        int lat;
        apply_reset();
        @(negedge clk);
        bus.req_valid = 4'hF;
        for (int h = 0; h < N; h++) set_req(h, OW'(h), $urandom, $urandom, RW'(h + 10));
        #1;
        for (int n = 0; n < 5; n++) begin
            exp_h = n % N;
            total_cnt++;
            if (bus.req_ready !== onehot(exp_h))
                $display("FAIL rr_grant[%0d]: req_ready=%b expected %b", n, bus.req_ready, onehot(exp_h));
            else pass_cnt++;
            @(negedge clk);
            #1;
            total_cnt++;
            if ({bus.req_ready, bus.mdu_valid, bus.mdu_hart_id} !== {4'b0, 1'b1, HW'(exp_h)})
                $display("FAIL rr_issue[%0d]: ready=%b mv=%b hart=%0d expected 0000 1 %0d",
                         n, bus.req_ready, bus.mdu_valid, bus.mdu_hart_id, exp_h);
            else pass_cnt++;
            lat = $urandom_range(1, 4);
            for (int c = 1; c < lat; c++) begin
                @(negedge clk);
                #1;
                total_cnt++;
                if (bus.req_ready !== 4'b0)
                    $display("FAIL rr_hold[%0d]: req_ready=%b expected 0000", n, bus.req_ready);
                else pass_cnt++;
            end
            @(negedge clk);
            unit_done(XL'(n), exp_h, RW'(exp_h + 10));
            #1;
            total_cnt++;
            if (bus.req_ready !== 4'b0)
                $display("FAIL rr_done_hold[%0d]: req_ready=%b expected 0000", n, bus.req_ready);
            else pass_cnt++;
            @(negedge clk);
            bus.mdu_done = 1'b0;
            if (n == 4) bus.req_valid = '0;
            #1;
            total_cnt++;
            if ({bus.wb_valid, bus.wb_hart_id, bus.wb_data} !== {1'b1, HW'(exp_h), XL'(n)})
                $display("FAIL rr_wb[%0d]: wv=%b hart=%0d data=%0d expected 1 %0d %0d",
                         n, bus.wb_valid, bus.wb_hart_id, bus.wb_data, exp_h, n);
            else pass_cnt++;
        end
    endtask

    task automatic test_busy_mask();
        apply_reset();
        @(negedge clk);
        bus.req_valid = 4'b0100;
        bus.mdu_busy  = 1'b1;
        set_req(2, 3'd4, 32'd100, 32'd7, 5'd3);
        for (int c = 0; c < 3; c++) begin
            #1;
            total_cnt++;
            if (bus.req_ready !== 4'b0)
                $display("FAIL busy_block[%0d]: req_ready=%b expected 0000", c, bus.req_ready);
            else pass_cnt++;
            @(negedge clk);
        end
        bus.mdu_busy = 1'b0;
        #1;
        total_cnt++;
        if (bus.req_ready !== 4'b0100)
            $display("FAIL busy_release: req_ready=%b expected 0100", bus.req_ready);
        else pass_cnt++;
    endtask

    task automatic test_pending_mask();
        apply_reset();
        @(negedge clk);
        bus.req_valid = 4'b0001;
        set_req(0, 3'd1, 32'd11, 32'd12, 5'd1);
        set_req(3, 3'd2, 32'd31, 32'd32, 5'd30);
        #1;
        total_cnt++;
        if (bus.req_ready !== 4'b0001)
            $display("FAIL pend_grant0: req_ready=%b expected 0001", bus.req_ready);
        else pass_cnt++;
        @(negedge clk);
        bus.req_valid = 4'b1001;
        for (int c = 0; c < 3; c++) begin
            #1;
            total_cnt++;
            if ({bus.req_ready, bus.hart_pending} !== {4'b0000, 4'b0001})
                $display("FAIL pend_block[%0d]: ready=%b pend=%b expected 0000 0001",
                         c, bus.req_ready, bus.hart_pending);
            else pass_cnt++;
            @(negedge clk);
        end
        unit_done(32'd5, 0, 5'd1);
        @(negedge clk);
        bus.mdu_done = 1'b0;
        #1;
        total_cnt++;
        if ({bus.wb_valid, bus.wb_hart_id, bus.req_ready, bus.hart_pending} !== {1'b1, 2'd0, 4'b1000, 4'b0000})
            $display("FAIL pend_next: wv=%b hart=%0d ready=%b pend=%b expected 1 0 1000 0000",
                     bus.wb_valid, bus.wb_hart_id, bus.req_ready, bus.hart_pending);
        else pass_cnt++;
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        total_cnt++;
        if ({bus.mdu_valid, bus.mdu_hart_id, bus.mdu_rd, bus.hart_pending} !== {1'b1, 2'd3, 5'd30, 4'b1000})
            $display("FAIL pend_issue3: mv=%b hart=%0d rd=%0d pend=%b expected 1 3 30 1000",
                     bus.mdu_valid, bus.mdu_hart_id, bus.mdu_rd, bus.hart_pending);
        else pass_cnt++;
    endtask

    task automatic test_done_new_req();
        apply_reset();
        @(negedge clk);
        bus.req_valid = 4'b0010;
        set_req(1, 3'd1, 32'd100, 32'd3, 5'd7);
        set_req(2, 3'd4, 32'd9, 32'd2, 5'd12);
        #1;
        total_cnt++;
        if (bus.req_ready !== 4'b0010)
            $display("FAIL dn_grant: req_ready=%b expected 0010", bus.req_ready);
        else pass_cnt++;
        @(negedge clk);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        unit_done(32'd300, 1, 5'd7);
        #1;
        total_cnt++;
        if (bus.req_ready !== 4'b0)
            $display("FAIL dn_done_cycle: req_ready=%b expected 0000", bus.req_ready);
        else pass_cnt++;
        @(negedge clk);
        bus.mdu_done = 1'b0;
        #1;
        total_cnt++;
        if ({bus.wb_valid, bus.wb_hart_id, bus.wb_rd, bus.wb_data, bus.req_ready}
            !== {1'b1, 2'd1, 5'd7, 32'd300, 4'b0100})
            $display("FAIL dn_next: wv=%b hart=%0d rd=%0d data=%0d ready=%b expected 1 1 7 300 0100",
                     bus.wb_valid, bus.wb_hart_id, bus.wb_rd, bus.wb_data, bus.req_ready);
        else pass_cnt++;
    endtask

    task automatic test_tag_mismatch();
        apply_reset();
        @(negedge clk);
        bus.req_valid = 4'b0010;
        set_req(1, 3'd5, 32'd50, 32'd5, 5'd5);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        unit_done(32'd10, 3, 5'd5);
        @(negedge clk);
        bus.mdu_done = 1'b0;
        #1;
        total_cnt++;
        if ({bus.wb_valid, bus.wb_hart_id, bus.wb_rd, bus.arb_err} !== {1'b1, 2'd1, 5'd5, 1'b1})
            $display("FAIL tag_wb: wv=%b hart=%0d rd=%0d err=%b expected 1 1 5 1",
                     bus.wb_valid, bus.wb_hart_id, bus.wb_rd, bus.arb_err);
        else pass_cnt++;
        repeat (5) @(negedge clk);
        #1;
        total_cnt++;
        if (bus.arb_err !== 1'b1)
            $display("FAIL tag_sticky: arb_err=%b expected 1", bus.arb_err);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bus.arb_err !== 1'b0)
            $display("FAIL tag_clear: arb_err=%b expected 0", bus.arb_err);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stray_done();
        apply_reset();
        @(negedge clk);
        unit_done(32'd99, 0, 5'd0);
        @(negedge clk);
        bus.mdu_done = 1'b0;
        #1;
        total_cnt++;
        if ({bus.arb_err, bus.wb_valid} !== 2'b10)
            $display("FAIL stray_done: err=%b wv=%b expected 1 0", bus.arb_err, bus.wb_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        @(negedge clk);
        bus.req_valid = 4'b0100;
        set_req(2, 3'd3, 32'hdeadbeef, 32'h12345678, 5'd17);
        @(negedge clk);
        bus.req_valid = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({bus.req_ready, bus.hart_pending, bus.mdu_valid, bus.wb_valid, bus.arb_err,
             bus.mdu_a, bus.mdu_b, bus.mdu_hart_id, bus.mdu_rd, bus.mdu_op} !== '0)
            $display("FAIL rst_wait: pend=%b mv=%b a=%h hart=%0d rd=%0d expected all 0",
                     bus.hart_pending, bus.mdu_valid, bus.mdu_a, bus.mdu_hart_id, bus.mdu_rd);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            total_cnt++;
            if ({bus.wb_valid, bus.mdu_valid, bus.hart_pending} !== '0)
                $display("FAIL rst_after[%0d]: wv=%b mv=%b pend=%b expected 0 0 0000",
                         c, bus.wb_valid, bus.mdu_valid, bus.hart_pending);
            else pass_cnt++;
        end
    endtask

`ifdef MULDIV_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int early;
        early = 0;
        apply_reset();
        @(negedge clk);
        bus.req_valid = 4'b0100;
        set_req(2, 3'd6, 32'd1000, 32'd0, 5'd9);
        @(negedge clk);
        bus.req_valid = '0;
        for (int w = 1; w <= TO; w++) begin
            @(negedge clk);
            #1;
            if (bus.wb_valid !== 1'b0) early++;
        end
        total_cnt++;
        if (early != 0)
            $display("FAIL to_early: early wb_valid cycles=%0d expected 0", early);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if ({bus.wb_valid, bus.wb_hart_id, bus.wb_rd, bus.wb_data, bus.arb_err, bus.hart_pending}
            !== {1'b1, 2'd2, 5'd9, 32'd0, 1'b1, 4'b0000})
            $display("FAIL to_wb: wv=%b hart=%0d rd=%0d data=%0d err=%b pend=%b expected 1 2 9 0 1 0000",
                     bus.wb_valid, bus.wb_hart_id, bus.wb_rd, bus.wb_data, bus.arb_err, bus.hart_pending);
        else pass_cnt++;
        @(negedge clk);
        unit_done(32'd77, 2, 5'd9);
        @(negedge clk);
        bus.mdu_done = 1'b0;
        #1;
        total_cnt++;
        if ({bus.wb_valid, bus.arb_err} !== 2'b01)
            $display("FAIL to_stray: wv=%b err=%b expected 0 1", bus.wb_valid, bus.arb_err);
        else pass_cnt++;
    endtask
`endif

    task automatic test_random();
        logic [N-1:0]    v;
        logic            busy;
        logic [OW-1:0]   e_op;
        logic [XL-1:0]   e_a;
        logic [XL-1:0]   e_b;
        logic [RW-1:0]   e_rd;
        logic [XL-1:0]   e_data;
        int              e_hart;
        int              g;
        int              lat;
        int              done_cnt;
        int              guard;
        bit              wb_pend;
        done_cnt = 0;
        guard    = 0;
        wb_pend  = 0;
        e_hart   = 0;
        e_rd     = '0;
        e_data   = '0;
        apply_reset();
        while (done_cnt < 40 && guard < 2000) begin
            guard++;
            @(negedge clk);
            v    = N'($urandom);
            busy = ($urandom_range(0, 3) == 0);
            for (int h = 0; h < N; h++) set_req(h, OW'($urandom), $urandom, $urandom, RW'($urandom));
            bus.req_valid = v;
            bus.mdu_busy  = busy;
            bus.mdu_done  = 1'b0;
            #1;
            total_cnt++;
            if (wb_pend) begin
                if ({bus.wb_valid, bus.wb_hart_id, bus.wb_rd, bus.wb_data} !== {1'b1, HW'(e_hart), e_rd, e_data})
                    $display("FAIL rnd_wb: wv=%b hart=%0d rd=%0d data=%h expected 1 %0d %0d %h",
                             bus.wb_valid, bus.wb_hart_id, bus.wb_rd, bus.wb_data, e_hart, e_rd, e_data);
                else pass_cnt++;
            end else begin
                if (bus.wb_valid !== 1'b0)
                    $display("FAIL rnd_no_wb: wb_valid=%b expected 0", bus.wb_valid);
                else pass_cnt++;
            end
            wb_pend = 0;
            g = model_pick(v, busy);
            total_cnt++;
            if (bus.req_ready !== onehot(g))
                $display("FAIL rnd_grant: req_valid=%b busy=%b req_ready=%b expected %b",
                         v, busy, bus.req_ready, onehot(g));
            else pass_cnt++;
            if (g >= 0) begin
                e_op      = bus.req_op[g*OW +: OW];
                e_a       = bus.req_a[g*XL +: XL];
                e_b       = bus.req_b[g*XL +: XL];
                e_rd      = bus.req_rd[g*RW +: RW];
                e_hart    = g;
                model_ptr = (g + 1) % N;
                @(negedge clk);
                bus.req_valid = N'($urandom);
                bus.mdu_busy  = 1'($urandom);
                for (int h = 0; h < N; h++) set_req(h, OW'($urandom), $urandom, $urandom, RW'($urandom));
                #1;
                total_cnt++;
                if ({bus.mdu_valid, bus.mdu_op, bus.mdu_a, bus.mdu_b, bus.mdu_hart_id, bus.mdu_rd,
                     bus.hart_pending, bus.req_ready} !== {1'b1, e_op, e_a, e_b, HW'(g), e_rd, onehot(g), 4'b0})
                    $display("FAIL rnd_issue: mv=%b op=%0d a=%h b=%h hart=%0d rd=%0d pend=%b expected 1 %0d %h %h %0d %0d %b",
                             bus.mdu_valid, bus.mdu_op, bus.mdu_a, bus.mdu_b, bus.mdu_hart_id, bus.mdu_rd,
                             bus.hart_pending, e_op, e_a, e_b, g, e_rd, onehot(g));
                else pass_cnt++;
                lat = $urandom_range(1, 5);
                for (int c = 1; c < lat; c++) begin
                    @(negedge clk);
                    bus.req_valid = N'($urandom);
                    #1;
                    total_cnt++;
                    if ({bus.req_ready, bus.mdu_valid, bus.hart_pending} !== {4'b0, 1'b0, onehot(g)})
                        $display("FAIL rnd_wait: ready=%b mv=%b pend=%b expected 0000 0 %b",
                                 bus.req_ready, bus.mdu_valid, bus.hart_pending, onehot(g));
                    else pass_cnt++;
                end
                @(negedge clk);
                e_data = $urandom;
                unit_done(e_data, g, e_rd);
                wb_pend = 1;
                done_cnt++;
            end
        end
        total_cnt++;
        if (done_cnt < 40)
            $display("FAIL rnd_budget: completed=%0d expected 40", done_cnt);
        else pass_cnt++;
        @(negedge clk);
        idle_inputs();
        #1;
        total_cnt++;
        if ({bus.wb_valid, bus.wb_hart_id, bus.wb_rd, bus.wb_data, bus.arb_err} !== {1'b1, HW'(e_hart), e_rd, e_data, 1'b0})
            $display("FAIL rnd_last: wv=%b hart=%0d data=%h err=%b expected 1 %0d %h 0",
                     bus.wb_valid, bus.wb_hart_id, bus.wb_data, bus.arb_err, e_hart, e_data);
        else pass_cnt++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        model_ptr = 0;
        rst_n     = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_busy_mask();
        test_pending_mask();
        test_done_new_req();
        test_tag_mismatch();
        test_stray_done();
        test_reset_mid_wait();
`ifdef MULDIV_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
